mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single cache-to-RAM line port between the instruction cache (read-only) and the data cache (read fill and dirty write-back).
- Sits between both cache controllers and the RAM model.
- Latches one request at a time and holds the RAM enable until the RAM responds.
- Returns the response and line to the granted cache only; round-robin on contention.

Parameters:
- ADDR_W, 32, address width.
- LINE_W, 256, cache line width in bits.
- OFFSET_W, 5, byte-offset bits in a line. Forced to zero on the RAM address.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable_icache_to_arb  in  1  icache line-read request, level.
- address_icache_to_arb  in  ADDR_W  icache miss address.
- response_arb_to_icache  out  1  one-cycle completion pulse to icache.
- data_arb_to_icache_o  out  LINE_W  line returned to icache.
- enable_dcache_to_arb  in  1  dcache request, level.
- write_dcache_to_arb  in  1  1 = write-back, 0 = line read.
- address_dcache_to_arb  in  ADDR_W  dcache address.
- data_dcache_to_arb_i  in  LINE_W  dirty line to write back.
- response_arb_to_dcache  out  1  one-cycle completion pulse to dcache.
- data_arb_to_dcache_o  out  LINE_W  line returned to dcache.
- enable_arb_to_ram  out  1  RAM access enable.
- write_arb_to_ram  out  1  RAM write strobe.
- address_arb_to_ram  out  ADDR_W  line-aligned RAM address.
- data_arb_to_ram_o  out  LINE_W  write line to RAM.
- response_ram_to_arb  in  1  RAM completion, one cycle.
- data_ram_to_arb_i  in  LINE_W  RAM read line, valid while the RAM completion pulse is high.

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous): state IDLE, all outputs 0, both return lines 0, last_grant=ICACHE (so dcache wins the first tie).
- States:
  - IDLE: sample the requests.
  - BUSY_I / BUSY_D: RAM access in flight.
  - DONE: one-cycle gap.
- IDLE, request seen on edge t:
  - Only one request active: grant it.
  - Both active: grant the one not equal to last_grant.
  - None active: stay in IDLE, RAM outputs 0.
- Grant at edge t:
  - From edge t+1: enable_arb_to_ram=1; address = requester address with low OFFSET_W bits cleared.
  - write_arb_to_ram = write_dcache_to_arb for dcache, 0 for icache.
  - data_arb_to_ram_o = data_dcache_to_arb_i for a dcache write, else 0.
  - All fields are captured at the grant edge and held constant for the whole access, even if requester inputs change.
- BUSY_x:
  - Hold the RAM outputs until response_ram_to_arb=1 is sampled (edge k).
  - At edge k+1: response_arb_to_x=1 for exactly one cycle, enable/write to RAM drop to 0, last_grant=x, state DONE.
  - On a read, data_arb_to_x_o is loaded with data_ram_to_arb_i at edge k+1 and holds until that requester's next read completes.
  - On a write, data_arb_to_dcache_o keeps its previous value.
- DONE: always goes to IDLE on the next edge. Requests are ignored, which gives the requester a cycle to drop its level request.
- Latency:
  - Request to RAM enable: 1 cycle.
  - RAM response to cache response: 1 cycle.
  - Earliest next RAM enable: k+3.
- Fairness: back-to-back contention alternates I, D, I, D.
- A request that drops before its grant is lost without error. A request that drops during BUSY does not abort the access; the response is still issued.
- The non-granted response output stays 0 throughout.
- RAM response in IDLE or DONE is ignored.
- Reset mid-access: outputs clear immediately and the RAM access is abandoned. Requesters must re-request after reset.
- No timeout: BUSY waits indefinitely for the RAM.

Decomposition:
- Shared package (mem_arb_pkg):
  - state encoding localparams: IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2, DONE=2'd3.
  - GRANT_I / GRANT_D constants.
  - LINE_W, ADDR_W, OFFSET_W defaults.
- Sub-module: rr_arb2, a 2-input round-robin picker with inputs req_i, req_d, last_grant and a one-hot grant output, combinational. Everything else stays flat.

Test Plan:
- Reset then idle: rst released, no requests for 10 cycles -> all outputs 0, enable_arb_to_ram never 1.
- Icache read:
  - Stimulus: request at address 0x0000_1234; RAM responds 3 cycles after enable with a line of all 0xA5 bytes.
  - Required: address_arb_to_ram=0x0000_1220, write=0.
  - Required: response_arb_to_icache pulses for 1 cycle with data_arb_to_icache_o = all 0xA5; response_arb_to_dcache stays 0.
- Dcache write-back:
  - Stimulus: write=1, address 0x8000_00FF, dirty line 0x1122..EEFF.
  - Required: RAM sees address 0x8000_00E0, write=1 and that line, all stable until the RAM responds.
  - Required: a 1-cycle response pulse; data_arb_to_dcache_o unchanged.
- Simultaneous requests after reset, both held:
  - Required: dcache is granted first, then icache.
  - Required: a third round with both requesting again grants dcache; the icache enable starts no earlier than 3 cycles after the dcache RAM response.
- Input change during BUSY: change address_dcache_to_arb and data_dcache_to_arb_i mid-access -> RAM outputs keep the values captured at grant.
- Reset mid-access: assert rst while BUSY_D -> enable_arb_to_ram falls without a clock edge. A later RAM response produces no cache response; after release the arbiter is in IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants for the cache-to-RAM line-port arbiter.
// State encodings, grant identities and default geometry.
package mem_arb_pkg;

   localparam int ADDR_W_DEF   = 32;
   localparam int LINE_W_DEF   = 256;
   localparam int OFFSET_W_DEF = 5;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] BUSY_I = 2'd1;
   localparam logic [1:0] BUSY_D = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   localparam logic GRANT_I = 1'b0;
   localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker; grant is one-hot {dcache, icache}.
// On a tie the requester that was not served last wins.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic       req_i,
   input  logic       req_d,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (req_i && req_d) begin
         grant = (last_grant == GRANT_I) ? 2'b10 : 2'b01;
      end else if (req_i) begin
         grant = 2'b01;
      end else if (req_d) begin
         grant = 2'b10;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single line-wide RAM port between icache and dcache.
// One access at a time, fields latched at grant, registered outputs.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int LINE_W   = LINE_W_DEF,
   parameter int OFFSET_W = OFFSET_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable_icache_to_arb,
   input  logic [ADDR_W-1:0] address_icache_to_arb,
   output logic              response_arb_to_icache,
   output logic [LINE_W-1:0] data_arb_to_icache_o,
   input  logic              enable_dcache_to_arb,
   input  logic              write_dcache_to_arb,
   input  logic [ADDR_W-1:0] address_dcache_to_arb,
   input  logic [LINE_W-1:0] data_dcache_to_arb_i,
   output logic              response_arb_to_dcache,
   output logic [LINE_W-1:0] data_arb_to_dcache_o,
   output logic              enable_arb_to_ram,
   output logic              write_arb_to_ram,
   output logic [ADDR_W-1:0] address_arb_to_ram,
   output logic [LINE_W-1:0] data_arb_to_ram_o,
   input  logic              response_ram_to_arb,
   input  logic [LINE_W-1:0] data_ram_to_arb_i
);

   localparam logic [ADDR_W-1:0] ALIGN =
      {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

   logic [1:0] state;
   logic       last_grant;
   logic [1:0] grant;

   rr_arb2 u_rr (
      .req_i      (enable_icache_to_arb),
      .req_d      (enable_dcache_to_arb),
      .last_grant (last_grant),
      .grant      (grant)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state                  <= IDLE;
         last_grant             <= GRANT_I;
         response_arb_to_icache <= 1'b0;
         response_arb_to_dcache <= 1'b0;
         data_arb_to_icache_o   <= '0;
         data_arb_to_dcache_o   <= '0;
         enable_arb_to_ram      <= 1'b0;
         write_arb_to_ram       <= 1'b0;
         address_arb_to_ram     <= '0;
         data_arb_to_ram_o      <= '0;
      end else begin
         response_arb_to_icache <= 1'b0;
         response_arb_to_dcache <= 1'b0;
         unique case (state)
            IDLE: begin
               if (grant[1]) begin
                  state              <= BUSY_D;
                  enable_arb_to_ram  <= 1'b1;
                  write_arb_to_ram   <= write_dcache_to_arb;
                  address_arb_to_ram <= address_dcache_to_arb & ALIGN;
                  data_arb_to_ram_o  <= write_dcache_to_arb ?
                                        data_dcache_to_arb_i : '0;
               end else if (grant[0]) begin
                  state              <= BUSY_I;
                  enable_arb_to_ram  <= 1'b1;
                  write_arb_to_ram   <= 1'b0;
                  address_arb_to_ram <= address_icache_to_arb & ALIGN;
                  data_arb_to_ram_o  <= '0;
               end
            end
            BUSY_I: begin
               if (response_ram_to_arb) begin
                  state                  <= DONE;
                  last_grant             <= GRANT_I;
                  response_arb_to_icache <= 1'b1;
                  data_arb_to_icache_o   <= data_ram_to_arb_i;
                  enable_arb_to_ram      <= 1'b0;
                  write_arb_to_ram       <= 1'b0;
                  address_arb_to_ram     <= '0;
                  data_arb_to_ram_o      <= '0;
               end
            end
            BUSY_D: begin
               if (response_ram_to_arb) begin
                  state                  <= DONE;
                  last_grant             <= GRANT_D;
                  response_arb_to_dcache <= 1'b1;
                  // a write-back leaves the last read line in place
                  if (!write_arb_to_ram) begin
                     data_arb_to_dcache_o <= data_ram_to_arb_i;
                  end
                  enable_arb_to_ram      <= 1'b0;
                  write_arb_to_ram       <= 1'b0;
                  address_arb_to_ram     <= '0;
                  data_arb_to_ram_o      <= '0;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected cache responses are
// queued as requests are issued and popped when a response pulses.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = ADDR_W_DEF;
   localparam int LW = LINE_W_DEF;
   localparam int OW = OFFSET_W_DEF;

   logic          clk;
   logic          rst;
   logic          enable_icache_to_arb;
   logic [AW-1:0] address_icache_to_arb;
   logic          response_arb_to_icache;
   logic [LW-1:0] data_arb_to_icache_o;
   logic          enable_dcache_to_arb;
   logic          write_dcache_to_arb;
   logic [AW-1:0] address_dcache_to_arb;
   logic [LW-1:0] data_dcache_to_arb_i;
   logic          response_arb_to_dcache;
   logic [LW-1:0] data_arb_to_dcache_o;
   logic          enable_arb_to_ram;
   logic          write_arb_to_ram;
   logic [AW-1:0] address_arb_to_ram;
   logic [LW-1:0] data_arb_to_ram_o;
   logic          response_ram_to_arb;
   logic [LW-1:0] data_ram_to_arb_i;

   typedef struct packed {
      logic          is_d;
      logic [LW-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   localparam logic [LW-1:0] L_A5  = {32{8'hA5}};
   localparam logic [LW-1:0] L_WB  =
      {2{128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF}};
   localparam logic [LW-1:0] L_W2  = {4{64'h0123_4567_89AB_CDEF}};
   localparam logic [LW-1:0] L_D1  = {8{32'hDEAD_0001}};
   localparam logic [LW-1:0] L_I1  = {8{32'h1CAC_0002}};
   localparam logic [LW-1:0] L_D2  = {8{32'hDEAD_0003}};
   localparam logic [LW-1:0] L_I2  = {8{32'h1CAC_0004}};
   localparam logic [LW-1:0] L_I3  = {8{32'h1CAC_0005}};

   mem_arbiter dut (
      .clk                    (clk),
      .rst                    (rst),
      .enable_icache_to_arb   (enable_icache_to_arb),
      .address_icache_to_arb  (address_icache_to_arb),
      .response_arb_to_icache (response_arb_to_icache),
      .data_arb_to_icache_o   (data_arb_to_icache_o),
      .enable_dcache_to_arb   (enable_dcache_to_arb),
      .write_dcache_to_arb    (write_dcache_to_arb),
      .address_dcache_to_arb  (address_dcache_to_arb),
      .data_dcache_to_arb_i   (data_dcache_to_arb_i),
      .response_arb_to_dcache (response_arb_to_dcache),
      .data_arb_to_dcache_o   (data_arb_to_dcache_o),
      .enable_arb_to_ram      (enable_arb_to_ram),
      .write_arb_to_ram       (write_arb_to_ram),
      .address_arb_to_ram     (address_arb_to_ram),
      .data_arb_to_ram_o      (data_arb_to_ram_o),
      .response_ram_to_arb    (response_ram_to_arb),
      .data_ram_to_arb_i      (data_ram_to_arb_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // response monitor: every pulse must match the head of the queue
   always @(negedge clk) begin
      exp_t          e;
      logic [1:0]    act;
      logic [LW-1:0] line;
      if (rst && (response_arb_to_icache || response_arb_to_dcache)) begin
         checks++;
         act = {response_arb_to_dcache, response_arb_to_icache};
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp d/i=%b, required no response",
                     act);
         end else begin
            e = exp_q.pop_front();
            line = e.is_d ? data_arb_to_dcache_o : data_arb_to_icache_o;
            if (act !== (e.is_d ? 2'b10 : 2'b01) || line !== e.data) begin
               errors++;
               $display("FAIL resp_line d/i=%b data=%h, required d=%0b data=%h",
                        act, line, e.is_d, e.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ram_serve(
      input  int            dly,
      input  logic [LW-1:0] line,
      input  bit            mutate,
      output logic [AW-1:0] a,
      output logic          w,
      output logic [LW-1:0] d,
      output bit            got,
      output bit            stable,
      output int            en_cyc,
      output int            rsp_cyc
   );
      got = 0;
      stable = 1;
      a = '0;
      w = 1'b0;
      d = '0;
      en_cyc = 0;
      rsp_cyc = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (enable_arb_to_ram === 1'b1) begin
            got = 1;
            break;
         end
      end
      if (!got) return;
      en_cyc = cyc;
      a = address_arb_to_ram;
      w = write_arb_to_ram;
      d = data_arb_to_ram_o;
      for (int i = 0; i < dly; i++) begin
         @(negedge clk);
         if (mutate && i == 0) begin
            address_dcache_to_arb = ~address_dcache_to_arb;
            data_dcache_to_arb_i  = ~data_dcache_to_arb_i;
         end
         if (enable_arb_to_ram !== 1'b1 || address_arb_to_ram !== a ||
             write_arb_to_ram !== w || data_arb_to_ram_o !== d)
            stable = 0;
      end
      response_ram_to_arb = 1'b1;
      data_ram_to_arb_i = line;
      rsp_cyc = cyc;
      tick();
      response_ram_to_arb = 1'b0;
      data_ram_to_arb_i = '0;
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      enable_icache_to_arb = 1'b0;
      enable_dcache_to_arb = 1'b0;
      write_dcache_to_arb = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      bit en_seen = 0;
      apply_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (enable_arb_to_ram !== 1'b0) en_seen = 1;
      end
      checks++;
      if (en_seen) begin
         errors++;
         $display("FAIL idle_enable seen=1, required 0");
      end
      checks++;
      if ({response_arb_to_icache, response_arb_to_dcache,
           data_arb_to_icache_o, data_arb_to_dcache_o,
           write_arb_to_ram, address_arb_to_ram,
           data_arb_to_ram_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs some output nonzero, required all 0");
      end
      tick();
   endtask

   task automatic test_icache_read();
      logic [AW-1:0] a;
      logic          w;
      logic [LW-1:0] d;
      bit            got, stable;
      int            ec, rc;
      address_icache_to_arb = 32'h0000_1234;
      enable_icache_to_arb = 1'b1;
      exp_q.push_back('{is_d: 1'b0, data: L_A5});
      ram_serve(2, L_A5, 0, a, w, d, got, stable, ec, rc);
      enable_icache_to_arb = 1'b0;
      checks++;
      if (!got || a !== 32'h0000_1220 || w !== 1'b0 || d !== '0) begin
         errors++;
         $display("FAIL icache_ram got=%0b addr=%h wr=%0b, required 1 00001220 0",
                  got, a, w);
      end
      checks++;
      if (!stable) begin
         errors++;
         $display("FAIL icache_hold stable=0, required 1");
      end
      @(negedge clk);
      checks++;
      if (response_arb_to_icache !== 1'b1 || response_arb_to_dcache !== 1'b0) begin
         errors++;
         $display("FAIL icache_pulse i=%b d=%b, required 1 0",
                  response_arb_to_icache, response_arb_to_dcache);
      end
      @(negedge clk);
      checks++;
      if (response_arb_to_icache !== 1'b0 || data_arb_to_icache_o !== L_A5) begin
         errors++;
         $display("FAIL icache_after resp=%b data=%h, required 0 %h",
                  response_arb_to_icache, data_arb_to_icache_o, L_A5);
      end
      tick();
   endtask

   task automatic do_write(input logic [AW-1:0] addr,
                           input logic [LW-1:0] line,
                           input logic [AW-1:0] exp_addr,
                           input bit mutate,
                           input string nm);
      logic [AW-1:0] a;
      logic          w;
      logic [LW-1:0] d;
      bit            got, stable;
      int            ec, rc;
      address_dcache_to_arb = addr;
      data_dcache_to_arb_i = line;
      write_dcache_to_arb = 1'b1;
      enable_dcache_to_arb = 1'b1;
      exp_q.push_back('{is_d: 1'b1, data: '0});
      ram_serve(3, L_D2, mutate, a, w, d, got, stable, ec, rc);
      enable_dcache_to_arb = 1'b0;
      write_dcache_to_arb = 1'b0;
      checks++;
      if (!got || a !== exp_addr || w !== 1'b1 || d !== line) begin
         errors++;
         $display("FAIL %s_ram got=%0b addr=%h wr=%0b data=%h, required addr=%h wr=1 data=%h",
                  nm, got, a, w, d, exp_addr, line);
      end
      checks++;
      if (!stable) begin
         errors++;
         $display("FAIL %s_hold stable=0, required 1", nm);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (response_arb_to_dcache !== 1'b0 || data_arb_to_dcache_o !== '0) begin
         errors++;
         $display("FAIL %s_after resp=%b data=%h, required 0 and line unchanged 0",
                  nm, response_arb_to_dcache, data_arb_to_dcache_o);
      end
      tick();
   endtask

   task automatic test_dcache_write();
      do_write(32'h8000_00FF, L_WB, 32'h8000_00E0, 0, "dwrite");
   endtask

   task automatic test_input_change();
      do_write(32'h0000_4044, L_W2, 32'h0000_4040, 1, "dchange");
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] a;
      logic          w;
      logic [LW-1:0] d;
      bit            got, stable;
      int            ec, rc, rc_prev;
      logic [AW-1:0] exp_a[4];
      logic [LW-1:0] line[4];
      exp_a[0] = 32'h3000_0040; line[0] = L_D1;
      exp_a[1] = 32'h2000_0000; line[1] = L_I1;
      exp_a[2] = 32'h3000_0040; line[2] = L_D2;
      exp_a[3] = 32'h2000_0000; line[3] = L_I2;
      apply_reset();
      tick();
      address_icache_to_arb = 32'h2000_0010;
      address_dcache_to_arb = 32'h3000_0047;
      write_dcache_to_arb = 1'b0;
      enable_icache_to_arb = 1'b1;
      enable_dcache_to_arb = 1'b1;
      for (int r = 0; r < 4; r++)
         exp_q.push_back('{is_d: (r % 2 == 0), data: line[r]});
      rc_prev = 0;
      for (int r = 0; r < 4; r++) begin
         ram_serve(1, line[r], 0, a, w, d, got, stable, ec, rc);
         if (r == 3) begin
            enable_icache_to_arb = 1'b0;
            enable_dcache_to_arb = 1'b0;
         end
         checks++;
         if (!got || a !== exp_a[r] || w !== 1'b0) begin
            errors++;
            $display("FAIL rr_round%0d got=%0b addr=%h wr=%0b, required addr=%h wr=0",
                     r, got, a, w, exp_a[r]);
         end
         if (r > 0) begin
            checks++;
            if (ec - rc_prev !== 3) begin
               errors++;
               $display("FAIL rr_gap%0d cycles=%0d, required 3",
                        r, ec - rc_prev);
            end
         end
         rc_prev = rc;
      end
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() !== 0 || enable_arb_to_ram !== 1'b0) begin
         errors++;
         $display("FAIL rr_drain pending=%0d en=%b, required 0 0",
                  exp_q.size(), enable_arb_to_ram);
      end
      tick();
   endtask

   task automatic test_mid_reset();
      logic [AW-1:0] a;
      logic          w;
      logic [LW-1:0] d;
      bit            got, stable, bad;
      int            ec, rc;
      got = 0;
      address_dcache_to_arb = 32'h0000_9000;
      write_dcache_to_arb = 1'b0;
      enable_dcache_to_arb = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (enable_arb_to_ram === 1'b1) begin
            got = 1;
            break;
         end
      end
      rst = 1'b0;
      #1;
      checks++;
      if (!got || {enable_arb_to_ram, write_arb_to_ram,
                   address_arb_to_ram} !== '0) begin
         errors++;
         $display("FAIL mid_reset got=%0b en=%b addr=%h, required 1 0 0",
                  got, enable_arb_to_ram, address_arb_to_ram);
      end
      enable_dcache_to_arb = 1'b0;
      tick();
      response_ram_to_arb = 1'b1;
      data_ram_to_arb_i = L_D1;
      tick();
      response_ram_to_arb = 1'b0;
      rst = 1'b1;
      tick();
      response_ram_to_arb = 1'b1;
      tick();
      response_ram_to_arb = 1'b0;
      data_ram_to_arb_i = '0;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (response_arb_to_icache || response_arb_to_dcache ||
             enable_arb_to_ram) bad = 1;
      end
      checks++;
      if (bad || data_arb_to_dcache_o !== '0) begin
         errors++;
         $display("FAIL stale_resp bad=%0b dline=%h, required 0 0",
                  bad, data_arb_to_dcache_o);
      end
      tick();
      address_icache_to_arb = 32'h0000_5555;
      enable_icache_to_arb = 1'b1;
      exp_q.push_back('{is_d: 1'b0, data: L_I3});
      ram_serve(2, L_I3, 0, a, w, d, got, stable, ec, rc);
      enable_icache_to_arb = 1'b0;
      checks++;
      if (!got || a !== 32'h0000_5540 || w !== 1'b0) begin
         errors++;
         $display("FAIL post_reset got=%0b addr=%h wr=%0b, required 1 00005540 0",
                  got, a, w);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL final_drain pending=%0d, required 0", exp_q.size());
      end
   endtask

   initial begin
      rst = 1'b0;
      enable_icache_to_arb = 1'b0;
      address_icache_to_arb = '0;
      enable_dcache_to_arb = 1'b0;
      write_dcache_to_arb = 1'b0;
      address_dcache_to_arb = '0;
      data_dcache_to_arb_i = '0;
      response_ram_to_arb = 1'b0;
      data_ram_to_arb_i = '0;
      #2;
      test_reset();
      test_icache_read();
      test_dcache_write();
      test_input_change();
      test_back_to_back();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
